// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: register address width, x0, and the
// in-flight destination entry tracked by the decode-stage hazard unit.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    // One tracked pipeline slot: does it hold a register write, and to which register.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/raw_hazard_scoreboard_if.sv
// ID-stage <-> hazard unit bundle. The ID stage (master) presents the decoded
// instruction and flush; the scoreboard (slave) returns stall/bubble/busy status.
interface raw_hazard_scoreboard_if #(
    parameter int CNT_WIDTH = 32
);
    import riscv_pkg::*;

    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs1_addr_i;
    logic                  id_rs1_used_i;
    logic [REG_ADDR_W-1:0] id_rs2_addr_i;
    logic                  id_rs2_used_i;
    logic [REG_ADDR_W-1:0] id_rd_addr_i;
    logic                  id_rd_wren_i;
    logic                  flush_i;
    logic                  stall_o;
    logic                  bubble_o;
    logic [31:0]           busy_o;
    logic [CNT_WIDTH-1:0]  stall_cycles_o;

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i,
               id_rd_addr_i, id_rd_wren_i, flush_i,
        input  stall_o, bubble_o, busy_o, stall_cycles_o
    );

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i,
               id_rd_addr_i, id_rd_wren_i, flush_i,
        output stall_o, bubble_o, busy_o, stall_cycles_o
    );

endinterface

// File: rtl/raw_hazard_scoreboard_sb_match.sv
// Compares one source register address against every tracked in-flight
// destination. x0 and unused sources never report a hit.
module sb_match
    import riscv_pkg::*;
#(
    parameter int NUM_STAGES = 3
) (
    input  sb_entry_t [NUM_STAGES-1:0] entries,
    input  logic [REG_ADDR_W-1:0]      addr,
    input  logic                       used,
    output logic                       hit
);

    logic any_match;

    // OR-reduce the per-entry address match; duplicates of one rd collapse to a single hit.
    always_comb begin
        any_match = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (entries[k].valid && (entries[k].rd == addr)) begin
                any_match = 1'b1;
            end
        end
    end

    assign hit = used & (addr != X0) & any_match;

endmodule

// File: rtl/raw_hazard_scoreboard.sv
// Decode-stage RAW hazard unit for the non-forwarding 5-stage pipeline.
// Tracks the destinations of the EX/MEM/WB instructions and holds the ID
// instruction while any of its sources still has a pending write. WB counts
// as pending because the register file reads the old value on the write cycle.
module raw_hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    raw_hazard_scoreboard_if.slave sb
);

    sb_entry_t [NUM_STAGES-1:0] entries;
    logic                       hit1;
    logic                       hit2;
    logic                       stall;
    logic                       issue;
    logic                       new_valid;
    logic [31:0]                busy;
    logic [CNT_WIDTH-1:0]       stall_cnt;

    sb_match #(.NUM_STAGES(NUM_STAGES)) u_match_rs1 (
        .entries (entries),
        .addr    (sb.id_rs1_addr_i),
        .used    (sb.id_rs1_used_i),
        .hit     (hit1)
    );

    sb_match #(.NUM_STAGES(NUM_STAGES)) u_match_rs2 (
        .entries (entries),
        .addr    (sb.id_rs2_addr_i),
        .used    (sb.id_rs2_used_i),
        .hit     (hit2)
    );

    // Flush wins over stall: the killed ID instruction must not hold the PC.
    // Outputs are forced quiet while reset is held, even if flush is asserted.
    assign stall     = rst_ni & sb.id_valid_i & (hit1 | hit2) & ~sb.flush_i;
    assign issue     = sb.id_valid_i & ~stall & ~sb.flush_i;
    assign new_valid = issue & sb.id_rd_wren_i & (sb.id_rd_addr_i != X0);

    // Shift the tracker one stage per clock; a stall or flush shifts in a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                entries[k] <= '0;
            end
        end else begin
            entries[0] <= {new_valid, sb.id_rd_addr_i};
            for (int k = 1; k < NUM_STAGES; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

    // Decode the valid entries into a per-register pending-write mask.
    always_comb begin
        busy = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (entries[k].valid) begin
                busy[entries[k].rd] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    // Count stalled cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign sb.stall_o        = stall;
    assign sb.bubble_o       = rst_ni & (stall | sb.flush_i);
    assign sb.busy_o         = busy;
    assign sb.stall_cycles_o = stall_cnt;

endmodule
